// File: rtl/upstream_order_arbiter.sv
// Shares one upstream order processor between N_CLIENTS order sources and a limit-update port.
// Define UPSTREAM_ARB_REJECT_EN to refuse orders whose amount exceeds the processor's current limit.
module upstream_order_arbiter #(
  parameter int N_CLIENTS   = 4,
  parameter int AMT_W       = 32,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_CLIENTS-1:0]       req_valid,
  input  logic [N_CLIENTS*AMT_W-1:0] req_amount,
  output logic [N_CLIENTS-1:0]       req_ready,
  input  logic                       max_valid,
  input  logic [AMT_W-1:0]           max_amount,
  output logic                       max_ready,
  input  logic [31:0]                max_to_trade,
  output logic                       new_order,
  output logic                       new_max,
  output logic [4:0]                 client_id,
  output logic [AMT_W-1:0]           amount,
  output logic                       busy,
  output logic [N_CLIENTS-1:0]       reject
);

  localparam int CW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int CMPW = (AMT_W > 32) ? AMT_W : 32;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt;
  logic [4:0]           last;
  logic                 grant_pend;
  logic                 cmd_max;
  logic                 can_arb;
  logic [N_CLIENTS-1:0] cand;
  logic [N_CLIENTS-1:0] pick_oh;
  logic [4:0]           pick;
  logic                 pick_found;
  logic [AMT_W-1:0]     pick_amt;
  logic                 rej_hit;
  int                   best;

  // Arbitration runs in IDLE and also at the end of GAP so that a new grant
  // lands HOLD_CYCLES+2 cycles after the previous one.
  assign can_arb = (state == GAP) || ((state == IDLE) && !grant_pend);
  // A client acknowledged this cycle still shows valid; keep it out of the search.
  assign cand    = req_valid & ~req_ready;

  always_comb begin
    best       = N_CLIENTS;
    pick       = '0;
    pick_oh    = '0;
    pick_amt   = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (cand[i] && (((i + 2*N_CLIENTS - int'(last) - 1) % N_CLIENTS) < best)) begin
        best = (i + 2*N_CLIENTS - int'(last) - 1) % N_CLIENTS;
        pick = 5'(i);
      end
    end
    pick_found = (best < N_CLIENTS);
    for (int i = 0; i < N_CLIENTS; i++) begin
      pick_oh[i] = pick_found && (pick == 5'(i));
      if (pick_oh[i]) pick_amt = req_amount[i*AMT_W +: AMT_W];
    end
  end

`ifdef UPSTREAM_ARB_REJECT_EN
  assign rej_hit = (max_to_trade != 32'd0) && (CMPW'(pick_amt) > CMPW'(max_to_trade));
`else
  logic unused_mtt;
  assign rej_hit    = 1'b0;
  assign unused_mtt = ^max_to_trade;
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (grant_pend) state_n = ISSUE;
      ISSUE:   if (cnt == '0) state_n = GAP;
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last       <= 5'(N_CLIENTS-1);
      grant_pend <= 1'b0;
      cmd_max    <= 1'b0;
      req_ready  <= '0;
      max_ready  <= 1'b0;
      reject     <= '0;
      client_id  <= '0;
      amount     <= '0;
    end else begin
      state      <= state_n;
      req_ready  <= '0;
      max_ready  <= 1'b0;
      reject     <= '0;
      grant_pend <= 1'b0;
      if (state == IDLE && grant_pend)         cnt <= CW'(HOLD_CYCLES-1);
      else if (state == ISSUE && cnt != '0)    cnt <= cnt - 1'b1;
      if (can_arb) begin
        if (max_valid) begin
          max_ready  <= 1'b1;
          cmd_max    <= 1'b1;
          amount     <= max_amount;
          client_id  <= '0;
          grant_pend <= 1'b1;
        end else if (pick_found) begin
          req_ready <= pick_oh;
          last      <= pick;
          if (rej_hit) begin
            reject <= pick_oh;
          end else begin
            cmd_max    <= 1'b0;
            amount     <= pick_amt;
            client_id  <= pick;
            grant_pend <= 1'b1;
          end
        end
      end
    end
  end

  assign new_order = (state == ISSUE) && !cmd_max;
  assign new_max   = (state == ISSUE) &&  cmd_max;
  assign busy      = (state == ISSUE) || (state == GAP);

endmodule

// File: tb/tb_upstream_order_arbiter.sv
// Directed bench for upstream_order_arbiter (N_CLIENTS=4, AMT_W=32, HOLD_CYCLES=4).
module tb_upstream_order_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam int H = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_amount = '0;
  logic [N-1:0]   req_ready;
  logic           max_valid = 1'b0;
  logic [W-1:0]   max_amount = '0;
  logic           max_ready;
  logic [31:0]    max_to_trade = '0;
  logic           new_order, new_max, busy;
  logic [4:0]     client_id;
  logic [W-1:0]   amount;
  logic [N-1:0]   reject;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  bit auto_drop = 1'b1;

  upstream_order_arbiter #(.N_CLIENTS(N), .AMT_W(W), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_amount(req_amount),
    .req_ready(req_ready), .max_valid(max_valid), .max_amount(max_amount),
    .max_ready(max_ready), .max_to_trade(max_to_trade), .new_order(new_order),
    .new_max(new_max), .client_id(client_id), .amount(amount), .busy(busy),
    .reject(reject)
  );

  always #5 clk = ~clk;

  // Requesters drop valid once they see their acknowledge.
  task automatic tick();
    @(posedge clk); #1;
    cycle++;
    if (auto_drop) begin
      req_valid = req_valid & ~req_ready;
      if (max_ready) max_valid = 1'b0;
    end
  endtask

  task automatic wait_grant(output logic [N-1:0] g, output int at);
    g = '0; at = -1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (req_ready != '0) begin g = req_ready; at = cycle; return; end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req_valid = '0; max_valid = 1'b0; max_to_trade = '0;
    auto_drop = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({req_ready, max_ready, new_order, new_max, busy, reject, client_id} !== '0 || amount !== '0) begin
      errors++; $display("FAIL reset_outputs: got rdy=%b mrdy=%b no=%b nm=%b busy=%b rej=%b id=%0d amt=%h, want all 0",
                         req_ready, max_ready, new_order, new_max, busy, reject, client_id, amount);
    end
    apply_reset();
    checks++;
    if (busy !== 1'b0 || req_ready !== '0) begin
      errors++; $display("FAIL reset_idle: busy=%b rdy=%b, want 0/0", busy, req_ready);
    end
  endtask

  task automatic test_single();
    logic [N-1:0] g; int t;
    apply_reset();
    req_amount[2*W +: W] = 32'h64;
    req_valid = 4'b0100;
    wait_grant(g, t);
    checks++;
    if (g !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", g); end
    checks++;
    if (new_order !== 1'b0) begin errors++; $display("FAIL single_no_early_strobe: got %b want 0", new_order); end
    for (int k = 1; k <= H; k++) begin
      tick();
      checks++;
      if (new_order !== 1'b1 || new_max !== 1'b0 || client_id !== 5'd2 || amount !== 32'h64 || busy !== 1'b1) begin
        errors++; $display("FAIL single_issue T+%0d: no=%b nm=%b id=%0d amt=%h busy=%b, want 1 0 2 64 1",
                           k, new_order, new_max, client_id, amount, busy);
      end
    end
    tick();
    checks++;
    if (new_order !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL single_gap: no=%b busy=%b, want 0 1", new_order, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] g; int t, prev;
    logic [N-1:0] exp_g [5];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    apply_reset();
    auto_drop = 1'b0;
    for (int i = 0; i < N; i++) req_amount[i*W +: W] = 32'(16 + i);
    req_valid = 4'b1111;
    prev = -1;
    for (int n = 0; n < 5; n++) begin
      wait_grant(g, t);
      checks++;
      if (g !== exp_g[n]) begin errors++; $display("FAIL rr_order #%0d: got %b want %b", n, g, exp_g[n]); end
      if (prev >= 0) begin
        checks++;
        if (t - prev != H + 2) begin errors++; $display("FAIL rr_spacing #%0d: got %0d want %0d", n, t - prev, H + 2); end
      end
      prev = t;
    end
    req_valid = '0;
    auto_drop = 1'b1;
  endtask

  task automatic test_limit_priority();
    logic [N-1:0] g; int t;
    apply_reset();
    for (int i = 0; i < N; i++) req_amount[i*W +: W] = 32'(32 + i);
    max_amount = 32'h1F4;
    max_valid  = 1'b1;
    req_valid  = 4'b1110;
    tick();
    checks++;
    if (max_ready !== 1'b1 || req_ready !== '0) begin
      errors++; $display("FAIL limit_ready: mrdy=%b rdy=%b, want 1 0000", max_ready, req_ready);
    end
    tick();
    checks++;
    if (new_max !== 1'b1 || new_order !== 1'b0 || amount !== 32'h1F4 || client_id !== 5'd0) begin
      errors++; $display("FAIL limit_issue: nm=%b no=%b amt=%h id=%0d, want 1 0 1f4 0", new_max, new_order, amount, client_id);
    end
    wait_grant(g, t);
    checks++;
    if (g !== 4'b0010) begin errors++; $display("FAIL limit_then_c1: got %b want 0010", g); end
    tick();
    checks++;
    if (new_order !== 1'b1 || client_id !== 5'd1 || amount !== 32'd33) begin
      errors++; $display("FAIL limit_c1_issue: no=%b id=%0d amt=%0d, want 1 1 33", new_order, client_id, amount);
    end
    wait_grant(g, t);
    checks++;
    if (g !== 4'b0100) begin errors++; $display("FAIL limit_then_c2: got %b want 0100", g); end
    wait_grant(g, t);
    checks++;
    if (g !== 4'b1000) begin errors++; $display("FAIL limit_then_c3: got %b want 1000", g); end
  endtask

  task automatic test_reset_mid_issue();
    logic [N-1:0] g; int t;
    apply_reset();
    req_amount[1*W +: W] = 32'd7;
    req_valid = 4'b0010;
    wait_grant(g, t);
    tick(); tick();
    checks++;
    if (new_order !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: no=%b want 1", new_order); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (new_order !== 1'b0 || new_max !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_drop: no=%b nm=%b busy=%b, want 0 0 0", new_order, new_max, busy);
    end
    tick();
    rst_n = 1'b1;
    req_valid = 4'b0101;
    wait_grant(g, t);
    checks++;
    if (g !== 4'b0001) begin errors++; $display("FAIL rst_mid_next: got %b want 0001", g); end
    req_valid = '0;
  endtask

  task automatic test_withdraw();
    logic [N-1:0] g; int t; int seen3;
    apply_reset();
    req_amount[0*W +: W] = 32'd5;
    req_amount[3*W +: W] = 32'd9;
    req_valid = 4'b0001;
    wait_grant(g, t);
    seen3 = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 2) req_valid[3] = 1'b1;
      if (k == 4) req_valid[3] = 1'b0;
      if (req_ready[3] || (new_order && client_id == 5'd3)) seen3++;
    end
    checks++;
    if (seen3 != 0) begin errors++; $display("FAIL withdraw: client3 activity %0d cycles, want 0", seen3); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL withdraw_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_reject();
    logic [N-1:0] g; int t;
    apply_reset();
    max_to_trade = 32'd100;
    req_amount[0*W +: W] = 32'd150;
    req_amount[1*W +: W] = 32'd50;
    req_valid = 4'b0011;
    wait_grant(g, t);
    checks++;
    if (g !== 4'b0001) begin errors++; $display("FAIL reject_grant0: got %b want 0001", g); end
`ifdef UPSTREAM_ARB_REJECT_EN
    checks++;
    if (reject !== 4'b0001 || busy !== 1'b0) begin
      errors++; $display("FAIL reject_pulse: rej=%b busy=%b, want 0001 0", reject, busy);
    end
    tick();
    checks++;
    if (req_ready !== 4'b0010 || reject !== '0 || new_order !== 1'b0) begin
      errors++; $display("FAIL reject_next: rdy=%b rej=%b no=%b, want 0010 0000 0", req_ready, reject, new_order);
    end
    tick();
    checks++;
    if (new_order !== 1'b1 || client_id !== 5'd1 || amount !== 32'd50) begin
      errors++; $display("FAIL reject_c1_issue: no=%b id=%0d amt=%0d, want 1 1 50", new_order, client_id, amount);
    end
`else
    checks++;
    if (reject !== '0) begin errors++; $display("FAIL reject_tied: rej=%b want 0000", reject); end
    tick();
    checks++;
    if (new_order !== 1'b1 || client_id !== 5'd0 || amount !== 32'd150) begin
      errors++; $display("FAIL noreject_issue: no=%b id=%0d amt=%0d, want 1 0 150", new_order, client_id, amount);
    end
`endif
    max_to_trade = '0;
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_limit_priority();
    test_reset_mid_issue();
    test_withdraw();
    test_reject();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/upstream_order_arbiter.md
# upstream_order_arbiter

Sequencer that shares one upstream order processor between `N_CLIENTS` order sources and one risk-limit configuration port. It arbitrates pending requests, with limit updates first and orders round-robin. It then drives the processor's `new_order`/`new_max`/`client_id`/`amount` inputs as a held strobe so the slower processor clock samples each command exactly once. It sits between the client order ports and the upstream processor top.

## Interface
- `N_CLIENTS`, 4: number of order requesters; legal range 2..32.
- `AMT_W`, 32: width of amount fields.
- `HOLD_CYCLES`, 4: `clk` cycles each command is held asserted; must be ≥ 1 and cover at least one processor-clock period.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  N_CLIENTS  per-client order pending.
- `req_amount`  in  N_CLIENTS*AMT_W  per-client order amount; client i occupies bits [i*AMT_W +: AMT_W].
- `req_ready`  out  N_CLIENTS  one-cycle acknowledge; request consumed.
- `max_valid`  in  1  limit update pending.
- `max_amount`  in  AMT_W  new trade limit.
- `max_ready`  out  1  one-cycle acknowledge of limit update.
- `max_to_trade`  in  32  current limit reported by the processor.
- `new_order`  out  1  order strobe to processor.
- `new_max`  out  1  limit-update strobe to processor.
- `client_id`  out  5  granted client index, zero-extended; 0 for limit updates.
- `amount`  out  AMT_W  command amount.
- `busy`  out  1  command in flight.
- `reject`  out  N_CLIENTS  order refused (see Configuration).

## Operation
- FSM states: IDLE, ISSUE, GAP.
- IDLE with nothing pending: stay in IDLE.
- IDLE with `max_valid`=1:
  - Grant the limit update.
  - Pulse `max_ready`.
  - Latch `max_amount`.
  - Go to ISSUE with `new_max`.
- IDLE otherwise, with some `req_valid` set:
  - Round-robin search starting at `last+1` mod N_CLIENTS.
  - Grant the first set bit i and pulse `req_ready[i]`.
  - Latch `req_amount[i]` and set `last`=i.
  - Go to ISSUE with `new_order`.
- Limit grants never move `last`.
- ISSUE:
  - Exactly one of `new_order`/`new_max` is high.
  - `client_id` and `amount` are stable.
  - A down-counter loaded with HOLD_CYCLES−1 decrements each cycle; at 0, go to GAP.
- GAP: one cycle with all strobes low so the processor sees deassertion, then go to IDLE.
- Requester rules:
  - A requester holds valid and amount stable until ready.
  - Dropping valid before ready withdraws the request with no side effects.
- `busy` is high in ISSUE and GAP.
- Reset (async assert, at any time, including mid-ISSUE):
  - All outputs go to 0 and the state goes to IDLE.
  - `last`=N_CLIENTS−1, so client 0 has first priority.
  - An in-flight command is dropped, not retried.

## Timing
- Grant at cycle T: ready pulses in T.
- Strobe is high in T+1..T+HOLD_CYCLES.
- GAP at T+HOLD_CYCLES+1.
- Earliest next grant at T+HOLD_CYCLES+2.
- Peak throughput: one command per HOLD_CYCLES+2 cycles.
- Outputs are registered; no combinational path from inputs to `new_order`/`new_max`/`client_id`/`amount`/`busy`.
- `req_ready`/`max_ready`/`reject` are registered decisions asserted in the grant cycle (state IDLE); at most one ready bit is high per cycle.
- Limit update and orders pending together: limit wins, and orders are served from the following IDLE.

## Configuration
- Macro `UPSTREAM_ARB_REJECT_EN`.
- Defined:
  - At grant, if `max_to_trade`≠0 and the latched amount is greater than `max_to_trade` (unsigned, zero-extended to 32), pulse `req_ready[i]` and `reject[i]` together.
  - No command is issued, the FSM stays in IDLE, and `last` advances to i.
  - Next grant possible at T+1.
- Not defined: `reject` is tied to 0 and all orders are issued.

## Test plan
- Single request:
  - Stimulus: after reset, client 2 requests amount 0x64, HOLD_CYCLES=4.
  - Required: `req_ready[2]` pulses at T; `new_order`=1, `client_id`=2, `amount`=0x64 for exactly T+1..T+4; low at T+5; `busy` low at T+6.
- Round-robin:
  - Stimulus: all 4 clients valid continuously.
  - Required: grant order 0,1,2,3,0, with grants spaced 6 cycles apart.
- Limit priority:
  - Stimulus: `max_valid` (0x1F4) and client 1 valid in the same cycle.
  - Required: `new_max` with `amount`=0x1F4 and `client_id`=0 first; then client 1's order; client 1 is granted before 2 and 3.
- Reset mid-ISSUE:
  - Stimulus: assert `rst_n`=0 at T+2.
  - Required: strobes and `busy` drop immediately; after release, the next grant goes to client 0.
- Reject, with `UPSTREAM_ARB_REJECT_EN`:
  - Stimulus: `max_to_trade`=100; client 0 requests 150, client 1 requests 50.
  - Required: `reject[0]` and `req_ready[0]` pulse with no strobe; client 1 is granted the next cycle and issued. Without the macro, 150 is issued.
- Withdraw:
  - Stimulus: client 3 asserts `req_valid` while `busy`, then drops it before IDLE.
  - Required: no ready and no strobe for client 3.
